// File: rtl/irq_controller_mm.sv
// Memory-mapped interrupt controller: mask, edge/level mode, W1C pending, EOI lock.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on every irq line.
module irq_controller_mm #(
  parameter int                NUM_IRQ   = 8,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h7F0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wr_en,
  output logic               sel,
  output logic [DATA_W-1:0]  rdata,
  output logic               int_req,
  input  logic               int_ack,
  output logic [DATA_W-1:0]  vector_out
);

  localparam int N = NUM_IRQ;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] mode;
  logic [N-1:0] irq_s;
  logic [N-1:0] irq_prev;
  logic [N-1:0] set_vec;
  logic [N-1:0] cand;
  logic [N-1:0] w1c;
  logic [N-1:0] ack_clr;
  logic         gie;
  logic [3:0]   isr_id;
  logic [3:0]   winner;
  logic         hit;
  logic         ack_ok;
  logic         eoi;
  logic         wr_sel;
  logic         wr_pend;
  logic         wr_mask;
  logic         wr_mode;
  logic         wr_ctrl;
  logic         unused_bits;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq;
`endif

  assign unused_bits = ^wdata;

  assign sel     = addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2];
  assign wr_sel  = sel & wr_en;
  assign wr_pend = wr_sel && addr[1:0] == 2'd0;
  assign wr_mask = wr_sel && addr[1:0] == 2'd1;
  assign wr_mode = wr_sel && addr[1:0] == 2'd2;
  assign wr_ctrl = wr_sel && addr[1:0] == 2'd3;

  assign set_vec = (mode & irq_s & ~irq_prev)
                 | (~mode & irq_s);
  assign cand    = pending & mask;
  assign hit     = |cand;
  assign w1c     = wr_pend ? wdata[N-1:0] : '0;
  assign ack_clr = ack_ok ? (N'(1) << winner) : '0;

  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) winner = 4'(i);
    end
  end

  always_comb begin
    state_nx = state;
    ack_ok   = 1'b0;
    eoi      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gie && hit) state_nx = REQ;
      end
      REQ: begin
        if (int_ack) begin
          if (gie && hit) begin
            ack_ok   = 1'b1;
            state_nx = SERVICE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      SERVICE: begin
        if (wr_ctrl && wdata[0]) begin
          eoi      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      int_req  <= 1'b0;
      pending  <= '0;
      mask     <= '0;
      mode     <= '1;
      gie      <= 1'b0;
      isr_id   <= '0;
      irq_prev <= '0;
    end else begin
      state    <= state_nx;
      int_req  <= state_nx == REQ;
      irq_prev <= irq_s;
      // set is OR-ed last so it beats both W1C and the ack clear
      pending  <= (pending & ~w1c & ~ack_clr) | set_vec;
      if (wr_mask) mask <= wdata[N-1:0];
      if (wr_mode) mode <= wdata[N-1:0];
      if (wr_ctrl) gie <= wdata[DATA_W-1];
      if (ack_ok) begin
        isr_id <= winner;
      end else if (eoi) begin
        isr_id <= '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (addr[1:0])
        2'd0: rdata[N-1:0] = pending;
        2'd1: rdata[N-1:0] = mask;
        2'd2: rdata[N-1:0] = mode;
        2'd3: begin
          rdata[DATA_W-1] = gie;
          rdata[DATA_W-2] = state == SERVICE;
          rdata[3:0]      = isr_id;
        end
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    vector_out = '0;
    if (int_ack && state == REQ) begin
      vector_out = ack_ok ? DATA_W'(winner)
                          : DATA_W'(NUM_IRQ);
    end
  end

endmodule
